// File: rtl/instr_encoder_loader_pkg.sv
// instr_pkg
// Shared definitions for the instruction encoder/loader and the CPU controller:
//   - op_e     : symbolic operation accepted on the encoder input (4 bits)
//   - OPC_*    : 6-bit primary opcodes of the supported MIPS subset
//   - FUNC_*   : 6-bit func codes of the R-type (opcode 0) instructions
//   - state_e  : loader session states
package instr_pkg;

    typedef enum logic [3:0] {
        NOP  = 4'd0,
        ADDU = 4'd1,
        SUBU = 4'd2,
        ORI  = 4'd3,
        LW   = 4'd4,
        SW   = 4'd5,
        BEQ  = 4'd6,
        LUI  = 4'd7,
        JAL  = 4'd8,
        J    = 4'd9,
        JR   = 4'd10,
        JALR = 4'd11
    } op_e;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03;
    localparam logic [5:0] OPC_BEQ     = 6'h04;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_LUI     = 6'h0F;
    localparam logic [5:0] OPC_LW      = 6'h23;
    localparam logic [5:0] OPC_SW      = 6'h2B;

    localparam logic [5:0] FUNC_JR     = 6'h08;
    localparam logic [5:0] FUNC_JALR   = 6'h09;
    localparam logic [5:0] FUNC_ADDU   = 6'h21;
    localparam logic [5:0] FUNC_SUBU   = 6'h23;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_e;

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// instr_pack
// Purely combinational packer: turns a symbolic instruction into a 32-bit
// MIPS word. Fields an operation does not use are forced to zero.
// Ports:
//   op      in  4   operation (instr_pkg::op_e encoding)
//   rs/rt/rd in 5   register fields
//   imm     in  16  immediate / branch offset
//   target  in  26  jump target
//   word    out 32  encoded instruction (0 for illegal ops)
//   illegal out 1   op is outside the supported set (12..15)
module instr_pack
    import instr_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Field layout: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] func[5:0].
    // Shamt is never used by the supported set, so it is always zero.
    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (op)
            NOP:  word = 32'h0;
            ADDU: word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FUNC_ADDU};
            SUBU: word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FUNC_SUBU};
            ORI:  word = {OPC_ORI, rs, rt, imm};
            LW:   word = {OPC_LW,  rs, rt, imm};
            SW:   word = {OPC_SW,  rs, rt, imm};
            BEQ:  word = {OPC_BEQ, rs, rt, imm};
            LUI:  word = {OPC_LUI, 5'b0, rt, imm};
            JAL:  word = {OPC_JAL, target};
            J:    word = {OPC_J,   target};
            JR:   word = {OPC_SPECIAL, rs, 15'b0, FUNC_JR};
            JALR: word = {OPC_SPECIAL, rs, 5'b0, rd, 5'b0, FUNC_JALR};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Streams symbolic instructions in over valid/ready, packs them into MIPS
// words and writes them to consecutive IM word addresses through a write
// port with backpressure. One-entry output holding register gives up to one
// word per cycle.
// Ports:
//   clk, reset (sync, active-low)
//   start/base_addr/max_words : begin a session at base_addr, at most max_words
//   finish                    : end the session early
//   in_valid/in_ready/in_op/in_rs/in_rt/in_rd/in_imm/in_target : input stream
//   im_we/im_ready/im_addr/im_wdata : IM write port
//   busy, done, err_illegal, count  : session status
module instr_encoder_loader
    import instr_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] max_words,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              im_we,
    input  logic              im_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic [ADDR_W-1:0] count
);

    state_e            state, state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] limit;
    logic [ADDR_W-1:0] accepted;
    logic [31:0]       pack_word;
    logic              pack_illegal;
    logic              accept, accept_ok, accept_bad, accept_last;
    logic              write_done, start_take;

    instr_pack u_pack (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    // The pending word always belongs at addr: addr only advances when that
    // word completes, so a word accepted in the same cycle lands at addr+1.
    assign im_addr     = addr;
    assign busy        = (state == RUN) || (state == DRAIN);
    assign done        = (state == DONE);
    assign in_ready    = (state == RUN) && (!im_we || im_ready) && (accepted < limit);
    assign accept      = in_valid && in_ready;
    assign accept_ok   = accept && !pack_illegal;
    assign accept_bad  = accept && pack_illegal;
    assign accept_last = accept_ok && ((accepted + ADDR_W'(1)) == limit);
    assign write_done  = im_we && im_ready;
    assign start_take  = start && ((state == IDLE) || (state == DONE) || (state == ERR));

    // Session state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DRAIN waits for the holding register to empty so the
    // last accepted word is always written before the session reports.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next = (max_words == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (finish || accept_bad || accept_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!im_we || im_ready) begin
                    state_next = err_illegal ? ERR : DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Session bookkeeping: address/limit/counters are reloaded on start,
    // otherwise advanced by completed writes and legal accepts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr        <= '0;
            limit       <= '0;
            accepted    <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
        end else if (start_take) begin
            addr        <= base_addr;
            limit       <= max_words;
            accepted    <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
        end else begin
            if (write_done) begin
                addr  <= addr + ADDR_W'(1);
                count <= count + ADDR_W'(1);
            end
            if (accept_ok) begin
                accepted <= accepted + ADDR_W'(1);
            end
            if (accept_bad) begin
                err_illegal <= 1'b1;
            end
        end
    end

    // Output holding register: a legal accept loads a new word (possibly in
    // the same cycle the previous one completes); otherwise the request is
    // held until IM takes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            im_we    <= 1'b0;
            im_wdata <= 32'h0;
        end else if (accept_ok) begin
            im_we    <= 1'b1;
            im_wdata <= pack_word;
        end else if (write_done) begin
            im_we    <= 1'b0;
        end
    end

endmodule
